// File: rtl/bus_dma_master.sv
// Single-channel bus DMA master: copies `length` 64-bit words from src to dst,
// one read (REQ/CAP) and one write (WR) bus transaction per word.
module bus_dma_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [7:0]  length,
  output logic        busy,
  output logic        done,
  output logic        m_req,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [63:0] m_dout,
  input  logic        m_grant,
  input  logic [63:0] m_din,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] data_q, data_d;
  logic [15:0] cnt_ext;

  assign cnt_ext   = {8'd0, cnt_q};
  assign m_dout    = data_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Bus handshake: m_req/m_wr/m_addr/m_dout are a request held stable until an
  // edge with m_grant=1 accepts it; read data arrives on m_din the cycle after
  // the granted read address, so CAP re-presents the address while capturing.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy    = (state_q != IDLE);
    done    = 1'b0;
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_addr  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != 8'd0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            len_d   = length;
            cnt_d   = 8'd0;
            state_d = REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      REQ: begin
        m_req  = 1'b1;
        m_addr = src_q + cnt_ext;
        if (m_grant) state_d = CAP;
      end
      CAP: begin
        m_req  = 1'b1;
        m_addr = src_q + cnt_ext;
        if (m_grant) begin
          data_d  = m_din;
          state_d = WR;
        end else begin
          state_d = REQ;
        end
      end
      WR: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = dst_q + cnt_ext;
        if (m_grant) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = (cnt_q + 8'd1 == len_q) ? DONE : REQ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
